// File: rtl/tff_bank_ctrl.sv
// Toggle-vector sequencer for a T flip-flop bank: up/down modulo counting or parallel load.
// Optional macro TFF_BANK_CTRL_SAT_EN: saturate at the range boundary instead of wrapping.
module tff_bank_ctrl #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             en,
  output logic [WIDTH-1:0] t_vec,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy
);

  localparam logic [WIDTH-1:0] LP_MAX  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] LP_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] LP_ZERO = '0;

  localparam logic [1:0] OP_STOP = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_UP   = 2'b01,
    S_DOWN = 2'b10,
    S_LOAD = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_ld;
  logic             r_tc;
  logic [WIDTH-1:0] w_t_vec;
  logic [WIDTH-1:0] w_step;
  logic             w_tc_next;
  logic             w_accept;
  logic             w_ready;
  logic [WIDTH-1:0] w_ld_clamped;

  assign w_ready      = (r_state != S_LOAD);
  assign w_accept     = cmd_valid & w_ready;
  assign w_ld_clamped = (cmd_data > LP_MAX) ? LP_MAX : cmd_data;

  always_comb begin
    w_next_state = r_state;
    w_t_vec      = '0;
    w_step       = r_q;
    w_tc_next    = 1'b0;
    case (r_state)
      S_UP: begin
        if (en) begin
          if (r_q == LP_MAX) begin
            w_tc_next = 1'b1;
`ifdef TFF_BANK_CTRL_SAT_EN
            w_step       = r_q;
            w_next_state = S_IDLE;
`else
            w_step       = LP_ZERO;
`endif
          end else begin
            w_step = r_q + LP_ONE;
          end
          w_t_vec = r_q ^ w_step;
        end
      end
      S_DOWN: begin
        if (en) begin
          if (r_q == LP_ZERO) begin
            w_tc_next = 1'b1;
`ifdef TFF_BANK_CTRL_SAT_EN
            w_step       = r_q;
            w_next_state = S_IDLE;
`else
            w_step       = LP_MAX;
`endif
          end else begin
            w_step = r_q - LP_ONE;
          end
          w_t_vec = r_q ^ w_step;
        end
      end
      S_LOAD: begin
        w_t_vec      = r_q ^ r_ld;
        w_next_state = S_IDLE;
      end
      default: begin
        w_t_vec = '0;
      end
    endcase

    // An accepted command suppresses this cycle's step; the new mode starts next edge.
    if (w_accept) begin
      w_t_vec   = '0;
      w_tc_next = 1'b0;
      case (cmd_op)
        OP_STOP: w_next_state = S_IDLE;
        OP_UP:   w_next_state = S_UP;
        OP_DOWN: w_next_state = S_DOWN;
        default: w_next_state = S_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_ld    <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_q     <= r_q ^ w_t_vec;
      r_tc    <= w_tc_next;
      if (w_accept && (cmd_op == 2'b11)) begin
        r_ld <= w_ld_clamped;
      end
    end
  end

  assign t_vec     = w_t_vec;
  assign q         = r_q;
  assign tc        = r_tc;
  assign busy      = (r_state != S_IDLE);
  assign cmd_ready = w_ready;

endmodule
